// File: rtl/tw36_seq.sv
// Twiddle-ROM address sequencer for the mixed-radix 36-point DFT.
// Walks (k1*n2) mod 36 with an adder only; tags are delay-matched to the ROM read.
module tw36_seq #(
    parameter int TW_LAT = 0,
    parameter int AW     = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic          conj_i,
    input  logic          en_i,
    output logic [AW-1:0] tw_addr_o,
    output logic          addr_vld_o,
    output logic          tw_vld_o,
    output logic          tw_first_o,
    output logic          tw_last_o,
    output logic          busy_o,
    output logic          done_o
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing indices; k1 past N1-1 means the last index is out
    // DONE  | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q;
    logic [1:0] mode_q;
    logic       conj_q;
    logic [3:0] k1_q, n2_q;
    logic [5:0] acc_q;
    logic [5:0] addr_q;
    logic       vld_q, first_q, last_q;

    logic [3:0] n1_lim, n2_lim;
    logic [5:0] addr_d;
    logic       step, row_end;

    always_comb begin
        n1_lim = 4'd5;
        n2_lim = 4'd5;
        case (mode_q)
            2'd1:    begin n1_lim = 4'd3; n2_lim = 4'd8; end
            2'd2:    begin n1_lim = 4'd8; n2_lim = 4'd3; end
            default: begin n1_lim = 4'd5; n2_lim = 4'd5; end
        endcase
    end

    // acc is at most 32, so the conjugate needs no modulo beyond the zero case
    assign addr_d  = (conj_q && (acc_q != 6'd0)) ? (6'd36 - acc_q) : acc_q;
    assign row_end = (n2_q == n2_lim);
    assign step    = (state_q == RUN) && en_i && (k1_q <= n1_lim);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            conj_q  <= 1'b0;
            k1_q    <= 4'd0;
            n2_q    <= 4'd0;
            acc_q   <= 6'd0;
            addr_q  <= 6'd0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            vld_q   <= step;
            first_q <= step && (k1_q == 4'd0) && (n2_q == 4'd0);
            last_q  <= step && (k1_q == n1_lim) && row_end;
            if (step) begin
                addr_q <= addr_d;
                if (row_end) begin
                    n2_q  <= 4'd0;
                    acc_q <= 6'd0;
                    k1_q  <= k1_q + 4'd1;
                end else begin
                    n2_q  <= n2_q + 4'd1;
                    acc_q <= acc_q + {2'b00, k1_q};
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q  <= (mode_i == 2'd3) ? 2'd0 : mode_i;
                        conj_q  <= conj_i;
                        k1_q    <= 4'd0;
                        n2_q    <= 4'd0;
                        acc_q   <= 6'd0;
                        state_q <= RUN;
                    end
                end
                RUN:     if (k1_q > n1_lim) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tw_addr_o  = {{(AW-6){1'b0}}, addr_q};
    assign addr_vld_o = vld_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    generate
        if (TW_LAT == 0) begin : g_lat0
            assign tw_vld_o   = vld_q;
            assign tw_first_o = first_q;
            assign tw_last_o  = last_q;
        end else begin : g_lat1
            logic dvld_q, dfirst_q, dlast_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    dvld_q   <= 1'b0;
                    dfirst_q <= 1'b0;
                    dlast_q  <= 1'b0;
                end else begin
                    dvld_q   <= vld_q;
                    dfirst_q <= first_q;
                    dlast_q  <= last_q;
                end
            end
            assign tw_vld_o   = dvld_q;
            assign tw_first_o = dfirst_q;
            assign tw_last_o  = dlast_q;
        end
    endgenerate

endmodule

// File: tb/tb_tw36_seq.sv
// Bench for tw36_seq: two instances (ROM latency 0 and 1) share stimulus and are
// compared every cycle against an index-arithmetic reference model.
module tb_tw36_seq;

    logic        clk = 1'b0;
    logic        rst_r = 1'b1, start_r = 1'b0, conj_r = 1'b0, en_r = 1'b0;
    logic [1:0]  mode_r = 2'd0;

    logic [10:0] a0, a1;
    logic        av0, tv0, tf0, tl0, b0, d0;
    logic        av1, tv1, tf1, tl1, b1, d1;

    always #5 clk = ~clk;

    tw36_seq #(.TW_LAT(0), .AW(11)) u0 (
        .clk_i(clk), .rst_i(rst_r), .start_i(start_r), .mode_i(mode_r), .conj_i(conj_r),
        .en_i(en_r), .tw_addr_o(a0), .addr_vld_o(av0), .tw_vld_o(tv0), .tw_first_o(tf0),
        .tw_last_o(tl0), .busy_o(b0), .done_o(d0));

    tw36_seq #(.TW_LAT(1), .AW(11)) u1 (
        .clk_i(clk), .rst_i(rst_r), .start_i(start_r), .mode_i(mode_r), .conj_i(conj_r),
        .en_i(en_r), .tw_addr_o(a1), .addr_vld_o(av1), .tw_vld_o(tv1), .tw_first_o(tf1),
        .tw_last_o(tl1), .busy_o(b1), .done_o(d1));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: frame progress as an index 0..35 plus edge-count timing
    int c = 0, fin = -100, idx = 0, m_n2 = 6;
    bit in_frame = 0, m_conj = 0;
    int e_addr = 0;
    bit e_vld = 0, e_first = 0, e_last = 0, e_busy = 0, e_done = 0;
    bit e1_vld = 0, e1_first = 0, e1_last = 0;

    int cap[64];
    int cap_n = 0;

    task automatic model_edge();
        bit idle_before, nv;
        int k1, n2, a;
        c++;
        if (rst_r) begin
            in_frame = 0; fin = -100; idx = 0;
            e_addr = 0; e_vld = 0; e_first = 0; e_last = 0; e_busy = 0; e_done = 0;
            e1_vld = 0; e1_first = 0; e1_last = 0;
        end else begin
            idle_before = !in_frame && (c >= fin + 3);
            e1_vld = e_vld; e1_first = e_first; e1_last = e_last;
            nv = 0;
            if (in_frame && en_r) begin
                k1 = idx / m_n2;
                n2 = idx % m_n2;
                a  = (k1 * n2) % 36;
                if (m_conj) a = (36 - a) % 36;
                e_addr  = a;
                e_first = (idx == 0);
                e_last  = (idx == 35);
                nv = 1;
                idx++;
                if (idx == 36) begin in_frame = 0; fin = c; end
            end else begin
                e_first = 0; e_last = 0;
            end
            e_vld = nv;
            if (idle_before && start_r) begin
                in_frame = 1; idx = 0; m_conj = conj_r;
                m_n2 = (mode_r == 2'd1) ? 9 : (mode_r == 2'd2) ? 4 : 6;
            end
            e_done = (c == fin + 1);
            e_busy = in_frame || (c <= fin + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("u0_addr", int'(a0), e_addr);   chk("u1_addr", int'(a1), e_addr);
        chk("u0_addr_vld", av0, e_vld);     chk("u1_addr_vld", av1, e_vld);
        chk("u0_tw_vld", tv0, e_vld);       chk("u1_tw_vld", tv1, e1_vld);
        chk("u0_tw_first", tf0, e_first);   chk("u1_tw_first", tf1, e1_first);
        chk("u0_tw_last", tl0, e_last);     chk("u1_tw_last", tl1, e1_last);
        chk("u0_busy", b0, e_busy);         chk("u1_busy", b1, e_busy);
        chk("u0_done", d0, e_done);         chk("u1_done", d1, e_done);
        if (av0 && cap_n < 64) begin
            cap[cap_n] = int'(a0);
            cap_n++;
        end
    endtask

    typedef struct {int mode; int conj; int idx; int exp;} vec_t;
    vec_t tbl[$];

    task automatic add_row(input int mode, input int conj, input int first_idx, input int vals[$]);
        foreach (vals[i]) tbl.push_back('{mode, conj, first_idx + i, vals[i]});
    endtask

    task automatic check_rows(input int mode, input int conj);
        int bad;
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].mode == mode && tbl[i].conj == conj)
                chk($sformatf("row_m%0d_c%0d_i%0d", mode, conj, tbl[i].idx), cap[tbl[i].idx], tbl[i].exp);
        bad = 0;
        for (int i = 0; i < cap_n; i++) if (cap[i] >= 36) bad++;
        chk("addr_range", bad, 0);
    endtask

    task automatic run_frame(input int mode, input int conj, input bit toggle);
        int edges;
        bit done_seen;
        cap_n = 0;
        mode_r = 2'(mode); conj_r = conj[0]; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        edges = 0; done_seen = 0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            en_r = toggle ? (i % 2 == 0) : 1'b1;
            tick();
            edges++;
            if (d0) done_seen = 1;
        end
        en_r = 1'b0;
        chk("frame_done_seen", done_seen, 1);
        chk("frame_len", edges, toggle ? 72 : 37);
        chk("vld_count", cap_n, 36);
        tick();
        chk("busy_after_done", b0, 0);
    endtask

    initial begin
        bit done_seen;
        add_row(0, 0, 0,  '{0, 0, 0, 0, 0, 0});
        add_row(0, 0, 6,  '{0, 1, 2, 3, 4, 5});
        add_row(0, 0, 30, '{0, 5, 10, 15, 20, 25});
        add_row(1, 1, 27, '{0, 33, 30, 27, 24, 21, 18, 15, 12});
        add_row(2, 0, 32, '{0, 8, 16, 24});

        rst_r = 1'b1;
        tick(); tick();
        chk("reset_addr", int'(a0), 0);
        chk("reset_busy", b1, 0);
        rst_r = 1'b0;
        tick();

        run_frame(0, 0, 0);
        check_rows(0, 0);
        run_frame(1, 1, 0);
        check_rows(1, 1);
        run_frame(2, 0, 1);
        check_rows(2, 0);

        // start mid-frame is ignored; start in DONE ignored; start in IDLE accepted
        cap_n = 0;
        mode_r = 2'd0; conj_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0; en_r = 1'b1;
        repeat (10) tick();
        mode_r = 2'd1; conj_r = 1'b1; start_r = 1'b1;
        tick();
        start_r = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 100 && !done_seen; i++) begin
            tick();
            if (d0) done_seen = 1;
        end
        chk("midrun_done_seen", done_seen, 1);
        chk("midrun_vld_count", cap_n, 36);
        check_rows(0, 0);
        en_r = 1'b0; start_r = 1'b1;
        tick();
        chk("start_in_done_ignored", b0, 0);
        tick();
        chk("start_in_idle_taken", b0, 1);
        start_r = 1'b0; en_r = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 100 && !done_seen; i++) begin
            tick();
            if (d0) done_seen = 1;
        end
        chk("restart_done_seen", done_seen, 1);
        en_r = 1'b0;
        tick(); tick();

        // reset mid-frame at index 20
        mode_r = 2'd0; conj_r = 1'b0; start_r = 1'b1;
        tick();
        start_r = 1'b0; en_r = 1'b1;
        repeat (20) tick();
        rst_r = 1'b1;
        tick();
        chk("rst_mid_tw_vld_lat1", tv1, 0);
        chk("rst_mid_busy", b0, 0);
        chk("rst_mid_addr", int'(a1), 0);
        rst_r = 1'b0; en_r = 1'b0;
        tick();
        chk("rst_mid_no_done", d0 | d1, 0);
        run_frame(0, 0, 0);
        check_rows(0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_r   = ($urandom_range(0, 499) == 0);
            start_r = ($urandom_range(0, 19) == 0);
            en_r    = ($urandom_range(0, 9) < 7);
            mode_r  = 2'($urandom_range(0, 3));
            conj_r  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tw36_seq.md
Name: tw36_seq

Overview:
- Address sequencer for the 36-entry twiddle ROM used between the two stages of the mixed-radix 36-point DFT in the PUSCH transform-precoding path.
- On `start`, walks the inter-stage twiddle indices (k1*n2) mod 36 for the selected factorisation, one index per `en` strobe.
- Drives the ROM `addr` port and produces a valid/first/last tag. The tag is delay-matched to the ROM output so the butterfly datapath consumes twiddle and tag together.
- Computes indices with an adder only, no multiplier. Supports conjugate (inverse-transform) indexing.

Parameters:
- TW_LAT, 0, ROM read latency in cycles: 0 = combinational ROM, 1 = ROM built with output register. Legal values 0..1.
- AW, 11, width of the ROM address port.

Ports:
- clk  in  1  master clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start strobe; accepted only in IDLE
- mode  in  2  factorisation, latched at start: 0 = 6x6 (N1=6, N2=6); 1 = 4x9 (N1=4, N2=9); 2 = 9x4 (N1=9, N2=4); 3 = reserved, treated as 0
- conj  in  1  latched at start; 1 = emit (36-a) mod 36 (conjugate twiddle)
- en  in  1  advance strobe, one per datapath sample; ignored outside RUN
- tw_addr  out  AW  ROM address, registered
- addr_vld  out  1  tw_addr holds a new index this cycle
- tw_vld  out  1  ROM output valid, = addr_vld delayed TW_LAT cycles
- tw_first  out  1  with tw_vld: first index of the frame
- tw_last  out  1  with tw_vld: last index of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last index is issued

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all counters 0.
  - tw_addr = 0; addr_vld, tw_vld, tw_first, tw_last, busy, done all 0.
  - Flushes the TW_LAT delay line.
  - Reset asserted mid-frame aborts the frame: no done pulse, and no tw_vld for addresses still in the delay line.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN. On this transition: latch mode and conj; clear k1, n2 and acc.
  - RUN --en on the final index--> DONE.
  - DONE --> IDLE unconditionally. done = 1 for exactly this one cycle.
  - start in RUN or DONE is ignored. Minimum frame-to-frame spacing is therefore 1 idle cycle.
- Counters:
  - Inner counter n2 runs 0..N2-1; outer counter k1 runs 0..N1-1. Frame length = N1*N2 = 36 `en` strobes.
  - acc holds k1*n2. On en:
    - if n2 < N2-1: n2++, acc += k1.
    - else: n2 = 0, acc = 0, k1++.
  - acc never exceeds (N1-1)*(N2-1) ≤ 32, so no modulo is required. acc is 6 bits wide.
- Address:
  - a = acc.
  - If conj = 1 and a != 0, emit 36-a. If conj = 1 and a = 0, emit 0.
  - Zero-extend to AW bits.
- Timing:
  - en sampled high at edge t: tw_addr and addr_vld update at t+1. addr_vld = 1 for one cycle per en.
  - en low: addr_vld = 0 and tw_addr holds its previous value.
  - tw_vld, tw_first and tw_last are addr_vld and its tags delayed by TW_LAT register stages. Total en-to-tw_vld latency is 1+TW_LAT cycles.
- Tags:
  - tw_first is tagged on index (k1=0, n2=0).
  - tw_last is tagged on index (k1=N1-1, n2=N2-1).
- done and the DONE state:
  - done asserts the cycle after the last index's addr_vld, i.e. coincident with it being registered plus one cycle.
  - done does not wait for the TW_LAT delay line to drain; the delay line continues to drain in DONE/IDLE.
- busy is 1 in RUN and DONE.
- Output range: tw_addr is always < 36. tw_addr never reaches the ROM's out-of-range zero path.

Test Plan:
- Reset, then mode=0, conj=0, start, en held high 36 cycles, TW_LAT=0 → addr sequence is k1=0: 0,0,0,0,0,0; k1=1: 0..5; k1=5: 0,5,10,15,20,25. tw_first on index 0, tw_last on index 35, done pulses one cycle after the last addr_vld, then busy drops.
- mode=1 (4x9), conj=1, en high → row k1=3 yields 0,33,30,27,24,21,18,15,12. Total 36 addr_vld pulses; no tw_addr ≥ 36.
- mode=2 (9x4), en toggled 1,0,1,0… → row k1=8 yields 0,8,16,24. tw_addr holds and addr_vld = 0 on en-low cycles. Frame completes after 72 cycles.
- TW_LAT=1, mode=0 → tw_vld, tw_first and tw_last lag addr_vld by exactly 1 cycle. The tw_last-tagged tw_vld appears in the same cycle done is high.
- start pulsed mid-RUN at index 10 → ignored, sequence continues unchanged. start again in the DONE cycle → ignored. start in the following IDLE cycle → new frame begins.
- rst asserted at index 20 → next cycle all outputs 0 and state IDLE. No done pulse, no stale tw_vld even with TW_LAT=1. A fresh start then restarts from index 0.
